uart_loader: RTL

Receive-side counterpart of the capture buffer dump path. It deserialises an 8N1 UART byte stream from the host and waits for a sync byte. It then delivers exactly CAPTURE_LENGTH samples as an addressed write stream, which the surrounding logic uses to load a capture buffer or fingerprint RAM for the matched filters. The block contains the bit-level receiver and the frame parser.

---
 rtl/uart_loader_if.sv | 23 ++
 rtl/uart_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_loader_if.sv
// Write-stream bundle driven by uart_loader: addressed sample strobe, frame status
// pulses and a debug view of both FSM states.
interface uart_loader_if #(
    parameter int AW = 10
);
    // axiov is a one-cycle strobe with no ready: axiod/addr are meaningful only while
    // axiov is high, and the consumer must take every strobe.
    logic          axiov;
    logic [7:0]    axiod;
    logic [AW-1:0] addr;
    logic          busy;
    logic          done;
    logic          frame_error;
    logic [3:0]    dbg_state;

    modport master (
        output axiov, axiod, addr, busy, done, frame_error, dbg_state
    );

    modport slave (
        input axiov, axiod, addr, busy, done, frame_error, dbg_state
    );
endinterface

// File: rtl/uart_loader.sv
// 8N1 UART receiver plus frame parser: after SYNC_BYTE, emits CAPTURE_LENGTH addressed samples.
// Optional inter-byte idle timeout in LOAD is built only when LOADER_TIMEOUT_EN is defined.
module uart_loader #(
    parameter int          CAPTURE_LENGTH = 1000,
    parameter int          CLKS_PER_BIT   = 868,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 20 * CLKS_PER_BIT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           uart_rx,
    uart_loader_if.master  o_ld
);
    localparam int AW = (CAPTURE_LENGTH > 1) ? $clog2(CAPTURE_LENGTH) : 1;
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [AW-1:0] LAST = AW'(CAPTURE_LENGTH - 1);

    typedef enum logic [2:0] {
        B_IDLE, B_START, B_DATA, B_STOP, B_WAIT_HIGH
    } bit_state_t;

    typedef enum logic {
        F_SYNC, F_LOAD
    } frame_state_t;

    logic r_sync1, r_sync2;
    logic w_rx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
        end
    end
    assign w_rx = r_sync2;

    bit_state_t     r_bit, w_bit_next;
    logic [CW-1:0]  r_cnt, w_cnt_next;
    logic [2:0]     r_idx, w_idx_next;
    logic [7:0]     r_shift, w_shift_next;
    logic           w_byte_valid, w_stop_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit   <= B_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_bit   <= w_bit_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_shift <= w_shift_next;
        end
    end

    // r_cnt holds the number of cycles since the last sample instant (or since t0).
    always_comb begin
        w_bit_next   = r_bit;
        w_cnt_next   = r_cnt + CW'(1);
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_byte_valid = 1'b0;
        w_stop_err   = 1'b0;
        case (r_bit)
            B_IDLE: begin
                w_cnt_next = CW'(1);
                if (!w_rx) w_bit_next = B_START;
            end
            B_START: begin
                if (r_cnt == HALF) begin
                    w_cnt_next = CW'(1);
                    w_idx_next = '0;
                    w_bit_next = w_rx ? B_IDLE : B_DATA;
                end
            end
            B_DATA: begin
                if (r_cnt == FULL) begin
                    w_cnt_next   = CW'(1);
                    w_shift_next = {w_rx, r_shift[7:1]};
                    w_idx_next   = r_idx + 3'd1;
                    if (r_idx == 3'd7) w_bit_next = B_STOP;
                end
            end
            B_STOP: begin
                if (r_cnt == FULL) begin
                    w_cnt_next   = CW'(1);
                    w_byte_valid = w_rx;
                    w_stop_err   = !w_rx;
                    w_bit_next   = w_rx ? B_IDLE : B_WAIT_HIGH;
                end
            end
            B_WAIT_HIGH: begin
                w_cnt_next = CW'(1);
                if (w_rx) w_bit_next = B_IDLE;
            end
            default: w_bit_next = B_IDLE;
        endcase
    end

    frame_state_t   r_frame, w_frame_next;
    logic           r_axiov, w_axiov_next;
    logic [7:0]     r_axiod, w_axiod_next;
    logic [AW-1:0]  r_addr, w_addr_next;
    logic [AW-1:0]  r_wptr, w_wptr_next;
    logic           r_done, w_done_next;
    logic           r_ferr, w_ferr_next;
`ifdef LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]  r_tmo, w_tmo_next;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame <= F_SYNC;
            r_axiov <= 1'b0;
            r_axiod <= '0;
            r_addr  <= '0;
            r_wptr  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
            r_tmo   <= '0;
`endif
        end else begin
            r_frame <= w_frame_next;
            r_axiov <= w_axiov_next;
            r_axiod <= w_axiod_next;
            r_addr  <= w_addr_next;
            r_wptr  <= w_wptr_next;
            r_done  <= w_done_next;
            r_ferr  <= w_ferr_next;
`ifdef LOADER_TIMEOUT_EN
            r_tmo   <= w_tmo_next;
`endif
        end
    end

    // r_addr is the address presented with axiod; r_wptr is the next slot to fill.
    always_comb begin
        w_frame_next = r_frame;
        w_axiov_next = 1'b0;
        w_axiod_next = r_axiod;
        w_addr_next  = r_addr;
        w_wptr_next  = r_wptr;
        w_done_next  = 1'b0;
        w_ferr_next  = 1'b0;
`ifdef LOADER_TIMEOUT_EN
        w_tmo_next   = r_tmo;
`endif
        case (r_frame)
            F_SYNC: begin
                if (w_stop_err) begin
                    w_ferr_next = 1'b1;
                end else if (w_byte_valid && r_shift == SYNC_BYTE) begin
                    w_frame_next = F_LOAD;
                    w_addr_next  = '0;
                    w_wptr_next  = '0;
`ifdef LOADER_TIMEOUT_EN
                    w_tmo_next   = '0;
`endif
                end
            end
            F_LOAD: begin
`ifdef LOADER_TIMEOUT_EN
                w_tmo_next = r_axiov ? TW'(1) : r_tmo + TW'(1);
`endif
                if (w_stop_err) begin
                    w_ferr_next  = 1'b1;
                    w_frame_next = F_SYNC;
                    w_addr_next  = '0;
                    w_wptr_next  = '0;
                end else if (w_byte_valid) begin
                    w_axiov_next = 1'b1;
                    w_axiod_next = r_shift;
                    w_addr_next  = r_wptr;
                    w_wptr_next  = r_wptr + AW'(1);
                end else if (r_axiov && r_addr == LAST) begin
                    w_done_next  = 1'b1;
                    w_frame_next = F_SYNC;
                    w_addr_next  = '0;
                    w_wptr_next  = '0;
`ifdef LOADER_TIMEOUT_EN
                end else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_ferr_next  = 1'b1;
                    w_frame_next = F_SYNC;
                    w_addr_next  = '0;
                    w_wptr_next  = '0;
`endif
                end
            end
            default: w_frame_next = F_SYNC;
        endcase
    end

    assign o_ld.axiov       = r_axiov;
    assign o_ld.axiod       = r_axiod;
    assign o_ld.addr        = r_addr;
    assign o_ld.busy        = (r_frame == F_LOAD);
    assign o_ld.done        = r_done;
    assign o_ld.frame_error = r_ferr;
    assign o_ld.dbg_state   = {r_frame, r_bit};
endmodule
